regfile_ctx_sequencer: RTL and testbench
========================================

Name: regfile_ctx_sequencer

Overview:
Context save/restore engine placed in front of the 32x32 register file of the multi-cycle CPU.
- When idle, it passes the core's register-file port signals straight through.
- On command, it takes ownership of one read port and the write port. It streams registers x1..x31 out over a valid/ready save channel, or writes x1..x31 from a valid/ready restore channel.
- busy stalls the core for the whole operation.

Parameters:
NUM_REGS, 32, number of architectural registers; index counter width is $clog2(NUM_REGS).
FIRST_REG, 1, first register sequenced; x0 is hardwired zero and is skipped.

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
save_start  in  1  request a save sequence; sampled only in IDLE
restore_start  in  1  request a restore sequence; sampled only in IDLE
busy  out  1  high in SAVE, RESTORE, DONE; core must stall
done  out  1  one-cycle pulse at end of sequence
core_rs1  in  5  core read address 1
core_rd  in  5  core write address
core_rd_din  in  32  core write data
core_write_enable  in  1  core RegWrite
rf_rs1  out  5  to register file rs1
rf_rd  out  5  to register file rd
rf_rd_din  out  32  to register file rd_din
rf_write_enable  out  1  to register file write_enable
rf_rs1_dout  in  32  asynchronous read data from register file port 1
sv_valid  out  1  save data valid
sv_data  out  32  save data
sv_ready  in  1  save consumer ready
rs_valid  in  1  restore data valid
rs_data  in  32  restore data
rs_ready  out  1  restore channel ready

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset), sampled on posedge clk.
- Reset state:
  - state=IDLE, idx=FIRST_REG.
  - busy=0, done=0, sv_valid=0, rs_ready=0.
  - Outputs follow the IDLE passthrough.
- FSM states: IDLE, SAVE, RESTORE, DONE.
- IDLE:
  - rf_rs1=core_rs1, rf_rd=core_rd, rf_rd_din=core_rd_din, rf_write_enable=core_write_enable (combinational).
  - save_start -> SAVE; else restore_start -> RESTORE. save wins if both are asserted.
  - idx=FIRST_REG on entry to either state.
- SAVE:
  - rf_rs1=idx; sv_valid=1; sv_data=rf_rs1_dout (combinational, zero added latency); rf_write_enable=0.
  - On sv_valid&&sv_ready: if idx==NUM_REGS-1 -> DONE, else idx<=idx+1.
  - With sv_ready=0, idx, sv_valid and sv_data hold stable.
- RESTORE:
  - rs_ready=1; rf_rd=idx; rf_rd_din=rs_data; rf_write_enable=rs_valid (the write lands on the same posedge as the handshake).
  - On rs_valid: if idx==NUM_REGS-1 -> DONE, else idx<=idx+1.
  - While rs_valid=0 there is no write and idx holds.
- DONE: done=1 for exactly one cycle, busy=1, no RF write, then -> IDLE. Passthrough resumes the following cycle.
- While not in IDLE:
  - core_* inputs are ignored; core writes are dropped, not queued.
  - save_start and restore_start are ignored.
- Sequence length:
  - Exactly NUM_REGS-FIRST_REG transfers (31 by default), strictly ascending idx.
  - Total busy cycles = transfers + stall cycles + 1 (DONE).
- idx never wraps: the terminal comparison occurs before increment.
- Reset mid-sequence: returns to IDLE at the next posedge; the partial transfer is abandoned, with no further writes or valid assertions.
- rf_rs2 is not touched; core port 2 remains directly connected.

Test Plan:
1. Reset, then save_start with sv_ready=1 -> 31 beats in consecutive cycles, order x1..x31. x2 beat = 0x00002ffc, all others 0. done pulses on cycle 32 after start; busy high for 32 cycles.
2. Save with sv_ready toggling 1,0,0,1... -> no beat lost or duplicated; sv_data stable while stalled; beat count still 31.
3. Restore: rs_data = 0x1000_0000+idx with rs_valid gaps every third cycle -> x1..x31 hold 0x1000_0001..0x1000_001F; x0 unchanged (0); done after the 31st accepted beat.
4. save_start and restore_start asserted in the same cycle -> SAVE runs; no RF write occurs; restore_start ignored during busy.
5. Assert reset after 10 save beats -> idle next cycle; sv_valid=0, busy=0, no done. A subsequent save restarts at x1.
6. IDLE passthrough: core writes 0xDEADBEEF to x5 -> rf_write_enable=1, rf_rd=5 the same cycle. A core write during RESTORE is dropped, and the restored value is kept.

Source files
------------

// File: rtl/regfile_ctx_sequencer.sv
// Context save/restore engine in front of the CPU register file.
// Passes core register-file traffic through when idle and streams x1..x31 out or in on command.
module regfile_ctx_sequencer #(
  parameter  int unsigned NUM_REGS  = 32,
  parameter  int unsigned FIRST_REG = 1,
  localparam int unsigned IDX_W     = $clog2(NUM_REGS),
  localparam int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_start,
  input  logic              restore_start,
  output logic              busy,
  output logic              done,
  input  logic [IDX_W-1:0]  core_rs1,
  input  logic [IDX_W-1:0]  core_rd,
  input  logic [DATA_W-1:0] core_rd_din,
  input  logic              core_write_enable,
  output logic [IDX_W-1:0]  rf_rs1,
  output logic [IDX_W-1:0]  rf_rd,
  output logic [DATA_W-1:0] rf_rd_din,
  output logic              rf_write_enable,
  input  logic [DATA_W-1:0] rf_rs1_dout,
  output logic              sv_valid,
  output logic [DATA_W-1:0] sv_data,
  input  logic              sv_ready,
  input  logic              rs_valid,
  input  logic [DATA_W-1:0] rs_data,
  output logic              rs_ready
);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAVE,
    ST_RESTORE,
    ST_DONE
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;

  // Sequencer state; the terminal check precedes the increment so idx never wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= FIRST_IDX;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_q <= FIRST_IDX;
          if (save_start)         state_q <= ST_SAVE;
          else if (restore_start) state_q <= ST_RESTORE;
        end
        ST_SAVE: begin
          if (sv_ready) begin
            if (idx_q == LAST_IDX) state_q <= ST_DONE;
            else                   idx_q   <= idx_q + IDX_W'(1);
          end
        end
        ST_RESTORE: begin
          if (rs_valid) begin
            if (idx_q == LAST_IDX) state_q <= ST_DONE;
            else                   idx_q   <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          idx_q   <= FIRST_IDX;
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= FIRST_IDX;
        end
      endcase
    end
  end

  // Port steering: passthrough by default, sequencer owns rs1/rd/write while busy
  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    sv_valid        = 1'b0;
    sv_data         = '0;
    rs_ready        = 1'b0;
    rf_rs1          = core_rs1;
    rf_rd           = core_rd;
    rf_rd_din       = core_rd_din;
    rf_write_enable = core_write_enable;
    case (state_q)
      ST_SAVE: begin
        busy            = 1'b1;
        rf_rs1          = idx_q;
        sv_valid        = 1'b1;
        sv_data         = rf_rs1_dout;
        rf_write_enable = 1'b0;
      end
      ST_RESTORE: begin
        busy            = 1'b1;
        rs_ready        = 1'b1;
        rf_rd           = idx_q;
        rf_rd_din       = rs_data;
        rf_write_enable = rs_valid;
      end
      ST_DONE: begin
        busy            = 1'b1;
        done            = 1'b1;
        rf_write_enable = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_ctx_sequencer.sv
// Randomized bench for regfile_ctx_sequencer with a register-file model and transaction-level reference.
module tb_regfile_ctx_sequencer;

  localparam int unsigned NREG  = 32;
  localparam int unsigned FIRST = 1;
  localparam int unsigned NXFER = NREG - FIRST;

  logic        clk = 1'b0;
  logic        reset;
  logic        save_start, restore_start;
  logic        busy, done;
  logic [4:0]  core_rs1, core_rd;
  logic [31:0] core_rd_din;
  logic        core_write_enable;
  logic [4:0]  rf_rs1, rf_rd;
  logic [31:0] rf_rd_din;
  logic        rf_write_enable;
  logic [31:0] rf_rs1_dout;
  logic        sv_valid;
  logic [31:0] sv_data;
  logic        sv_ready;
  logic        rs_valid;
  logic [31:0] rs_data;
  logic        rs_ready;
  logic        rf_init;

  logic [31:0] rf_mem  [NREG];
  logic [31:0] exp_mem [NREG];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_ctx_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .save_start        (save_start),
    .restore_start     (restore_start),
    .busy              (busy),
    .done              (done),
    .core_rs1          (core_rs1),
    .core_rd           (core_rd),
    .core_rd_din       (core_rd_din),
    .core_write_enable (core_write_enable),
    .rf_rs1            (rf_rs1),
    .rf_rd             (rf_rd),
    .rf_rd_din         (rf_rd_din),
    .rf_write_enable   (rf_write_enable),
    .rf_rs1_dout       (rf_rs1_dout),
    .sv_valid          (sv_valid),
    .sv_data           (sv_data),
    .sv_ready          (sv_ready),
    .rs_valid          (rs_valid),
    .rs_data           (rs_data),
    .rs_ready          (rs_ready)
  );

  // Register file behind the sequencer: x0 hardwired zero, x2 preset as stack pointer
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < int'(NREG); i++) rf_mem[i] <= (i == 2) ? 32'h0000_2ffc : 32'h0;
    end else if (rf_write_enable && rf_rd != 5'd0) begin
      rf_mem[rf_rd] <= rf_rd_din;
    end
  end
  assign rf_rs1_dout = rf_mem[rf_rs1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_core(input bit allow_we);
    core_rs1          = 5'($urandom);
    core_rd           = 5'($urandom_range(1, 31));
    core_rd_din       = $urandom;
    core_write_enable = allow_we ? 1'($urandom) : 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_svv"}, 32'(sv_valid), 32'd0);
    check_eq({tag, "_rsr"}, 32'(rs_ready), 32'd0);
    check_eq({tag, "_rs1"}, 32'(rf_rs1), 32'(core_rs1));
    check_eq({tag, "_rd"}, 32'(rf_rd), 32'(core_rd));
    check_eq({tag, "_din"}, rf_rd_din, core_rd_din);
    check_eq({tag, "_we"}, 32'(rf_write_enable), 32'(core_write_enable));
  endtask

  task automatic compare_rf(input string tag);
    for (int i = 0; i < int'(NREG); i++) check_eq($sformatf("%s_x%0d", tag, i), rf_mem[i], exp_mem[i]);
  endtask

  // mode: 0 always ready, 1 ready pattern 1,0,0,..., 2 random; abort_at>=0 resets after that many beats
  task automatic do_save(input int mode, input bit both, input int abort_at);
    int beats = 0;
    int stalls = 0;
    int cyc = 0;
    bit fin = 0;
    bit prev_stall = 0;
    logic [31:0] prev_data = '0;
    @(negedge clk);
    rand_core(1'b0);
    save_start = 1'b1;
    restore_start = both;
    sv_ready = 1'b0;
    rs_valid = 1'($urandom);
    rs_data = $urandom;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      save_start    = 1'($urandom);
      restore_start = 1'($urandom);
      rs_valid      = 1'($urandom);
      rs_data       = $urandom;
      rand_core(1'b1);
      case (mode)
        0:       sv_ready = 1'b1;
        1:       sv_ready = ((cyc - 1) % 3) == 0;
        default: sv_ready = 1'($urandom);
      endcase
      #1;
      check_eq("sv_busy", 32'(busy), 32'd1);
      check_eq("sv_we", 32'(rf_write_enable), 32'd0);
      check_eq("sv_rsr", 32'(rs_ready), 32'd0);
      if (beats < int'(NXFER)) begin
        check_eq("sv_valid", 32'(sv_valid), 32'd1);
        check_eq("sv_done0", 32'(done), 32'd0);
        check_eq("sv_rs1", 32'(rf_rs1), 32'(FIRST + beats));
        check_eq("sv_data", sv_data, exp_mem[FIRST + beats]);
        if (prev_stall) check_eq("sv_hold", sv_data, prev_data);
        prev_data  = sv_data;
        prev_stall = !sv_ready;
        if (sv_ready) beats++;
        else          stalls++;
        if (abort_at >= 0 && beats == abort_at) begin
          @(negedge clk);
          reset = 1'b1;
          save_start = 1'b0;
          restore_start = 1'b0;
          @(negedge clk);
          reset = 1'b0;
          rand_core(1'b0);
          #1;
          check_idle("abort");
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check_eq("abort_nodone", 32'(done), 32'd0);
            check_eq("abort_nobusy", 32'(busy), 32'd0);
          end
          return;
        end
      end else begin
        check_eq("sv_done", 32'(done), 32'd1);
        check_eq("sv_valid_done", 32'(sv_valid), 32'd0);
        check_eq("sv_len", 32'(cyc), 32'(int'(NXFER) + stalls + 1));
        fin = 1;
      end
    end
    check_eq("sv_timeout", 32'(fin), 32'd1);
    @(negedge clk);
    save_start = 1'b0;
    restore_start = 1'b0;
    rand_core(1'b0);
    #1;
    check_idle("sv_post");
  endtask

  // mode: 0 data 0x1000_0000+idx with a gap every third cycle, 1 random data and valid
  task automatic do_restore(input int mode);
    int beats = 0;
    int stalls = 0;
    int cyc = 0;
    bit fin = 0;
    @(negedge clk);
    rand_core(1'b0);
    save_start = 1'b0;
    restore_start = 1'b1;
    rs_valid = 1'b0;
    sv_ready = 1'($urandom);
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      save_start    = 1'($urandom);
      restore_start = 1'($urandom);
      sv_ready      = 1'($urandom);
      rand_core(1'b1);
      if (mode == 0) begin
        rs_valid = (cyc % 3) != 0;
        rs_data  = 32'h1000_0000 + 32'(FIRST + beats);
      end else begin
        rs_valid = 1'($urandom);
        rs_data  = $urandom;
      end
      #1;
      check_eq("rs_busy", 32'(busy), 32'd1);
      check_eq("rs_svv", 32'(sv_valid), 32'd0);
      if (beats < int'(NXFER)) begin
        check_eq("rs_ready", 32'(rs_ready), 32'd1);
        check_eq("rs_done0", 32'(done), 32'd0);
        check_eq("rs_we", 32'(rf_write_enable), 32'(rs_valid));
        if (rs_valid) begin
          check_eq("rs_rd", 32'(rf_rd), 32'(FIRST + beats));
          check_eq("rs_din", rf_rd_din, rs_data);
          exp_mem[FIRST + beats] = rs_data;
          beats++;
        end else begin
          stalls++;
        end
      end else begin
        check_eq("rs_done", 32'(done), 32'd1);
        check_eq("rs_ready_done", 32'(rs_ready), 32'd0);
        check_eq("rs_we_done", 32'(rf_write_enable), 32'd0);
        check_eq("rs_len", 32'(cyc), 32'(int'(NXFER) + stalls + 1));
        fin = 1;
      end
    end
    check_eq("rs_timeout", 32'(fin), 32'd1);
    @(negedge clk);
    save_start = 1'b0;
    restore_start = 1'b0;
    rs_valid = 1'b0;
    rand_core(1'b0);
    #1;
    check_idle("rs_post");
    compare_rf("rs_rf");
  endtask

  initial begin
    reset = 1'b1;
    rf_init = 1'b1;
    save_start = 1'b0;
    restore_start = 1'b0;
    sv_ready = 1'b0;
    rs_valid = 1'b0;
    rs_data = '0;
    rand_core(1'b0);
    for (int i = 0; i < int'(NREG); i++) exp_mem[i] = (i == 2) ? 32'h0000_2ffc : 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rf_init = 1'b0;
    @(negedge clk);
    rand_core(1'b1);
    #1;
    check_idle("reset");
    @(negedge clk);
    core_write_enable = 1'b0;

    do_save(0, 1'b0, -1);
    do_save(1, 1'b0, -1);
    do_save(2, 1'b0, -1);
    do_restore(0);
    do_save(0, 1'b1, -1);
    compare_rf("both_rf");
    do_save(2, 1'b0, 10);
    compare_rf("abort_rf");
    do_save(0, 1'b0, -1);

    // Idle passthrough write of 0xDEADBEEF to x5
    @(negedge clk);
    core_rs1 = 5'd5;
    core_rd = 5'd5;
    core_rd_din = 32'hDEAD_BEEF;
    core_write_enable = 1'b1;
    #1;
    check_eq("pt_we", 32'(rf_write_enable), 32'd1);
    check_eq("pt_rd", 32'(rf_rd), 32'd5);
    check_eq("pt_din", rf_rd_din, 32'hDEAD_BEEF);
    exp_mem[5] = 32'hDEAD_BEEF;
    @(negedge clk);
    core_write_enable = 1'b0;
    #1;
    check_eq("pt_read", rf_rs1_dout, 32'hDEAD_BEEF);

    do_restore(1);
    do_save(2, 1'b0, -1);
    do_restore(0);
    do_save(0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
